register_file_sb: RTL and testbench
===================================

// Module: register_file_sb
// PURPOSE
//   Parametrised multi-bit register file with a per-register pending scoreboard.
//   Provides one write port, one reserve (issue) port and two combinational read ports.
//   Each read port reports data plus a ready flag.
//   Sits between the decode/issue stage (reserves destinations) and writeback (fills them).
//   Register 0 is hardwired to zero.
// PARAMETERS
//   DW  8  data width of every register and bus
//   AW  3  address width; depth = 2**AW registers (r0 .. r(2**AW-1))
// PORTS
//   Clk     in   1      rising-edge clock
//   Rst     in   1      synchronous reset, active-high
//   WEN     in   1      write enable (writeback)
//   RW      in   AW     write address
//   busW    in   DW     write data
//   ISS     in   1      issue: reserve register RI as pending
//   RI      in   AW     reserve address
//   RX      in   AW     read address, port X
//   RY      in   AW     read address, port Y
//   busX    out  DW     read data, port X (combinational)
//   busY    out  DW     read data, port Y (combinational)
//   RDYX    out  1      port X register not pending (combinational)
//   RDYY    out  1      port Y register not pending (combinational)
//   PEND    out  AW+1   count of pending registers (registered)
//   ISSERR  out  1      one-cycle pulse: previous cycle issued to an already-pending reg
// BEHAVIOUR
//   Reset: on posedge Clk with Rst=1
//     - all registers <= 0; all pending bits <= 0; PEND <= 0; ISSERR <= 0
//     - WEN and ISS are ignored in that cycle
//     - reset mid-operation discards every outstanding reservation
//   Write: posedge Clk, WEN=1, RW!=0
//     - reg[RW] <= busW; pend[RW] <= 0
//     - writing a non-pending register is a legal plain write
//     - WEN with RW=0: no effect
//   Issue: posedge Clk, ISS=1, RI!=0
//     - pend[RI] <= 1
//     - ISS with RI=0: no effect, no error
//   ISS and WEN in the same cycle
//     - different addresses: both take effect
//     - same address: data is written AND pend stays/becomes 1 (new reservation wins)
//   ISSERR
//     - <= 1 for exactly one cycle after ISS=1, RI!=0, pend[RI]=1 before the edge
//       and not simultaneously cleared by WEN to the same address
//     - otherwise <= 0
//     - the register remains pending
//   PEND
//     - tracks popcount(pend) exactly; updated on the same edge as pend
//     - +1 when a clear bit is set, -1 when a set bit is cleared
//     - both in one cycle: net 0
//     - saturation impossible (max 2**AW-1)
//   Read (zero latency, combinational)
//     - busX = reg[RX], RDYX = ~pend[RX]; same for Y
//     - RX=0 gives busX=0, RDYX=1
//     - both ports may address the same register
//   Width: busW stored unmodified; no sign/zero extension anywhere
// CONFIGURATION
//   REGFILE_BYPASS_EN
//     - defined: when WEN=1, RW!=0 and RW==RX, then busX=busW and RDYX=1 in the same
//       cycle (write-to-read forwarding); likewise for port Y. Forwarding ignores ISS.
//     - undefined: reads return the pre-edge register contents; ready follows pend only.
// TESTING
//   1. Rst=1 one cycle after random writes -> every busX/busY=0, RDYX=RDYY=1, PEND=0, ISSERR=0.
//   2. WEN, RW=0, busW=8'hAA; RX=0 -> busX=0, RDYX=1. WEN, RW=5, busW=8'h3C; next cycle RX=5 -> busX=8'h3C.
//   3. ISS RI=3 -> RDYX(RX=3)=0, PEND=1. WEN RW=3, busW=8'h11 -> busX=8'h11, RDYX=1, PEND=0.
//   4. ISS RI=4 twice in consecutive cycles -> ISSERR=1 for one cycle after the 2nd, PEND=1.
//      ISS+WEN both to r4 same cycle -> r4 updated, still pending, PEND=1, ISSERR=0.
//   5. ISS RI=2 and WEN RW=6 same cycle (r6 pending) -> PEND unchanged, RDY(r2)=0, RDY(r6)=1.
//   6. Bypass (macro defined): WEN RW=7, busW=8'h5A, RX=RY=7 same cycle -> busX=busY=8'h5A, RDYX=RDYY=1.
//      Macro undefined: old r7 contents.

Source files
------------

// File: rtl/register_file_sb.sv
// Register file with a per-register pending scoreboard: one write, one reserve, two read ports.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module register_file_sb #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 3
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          WEN,
    input  logic [AW-1:0] RW,
    input  logic [DW-1:0] busW,
    input  logic          ISS,
    input  logic [AW-1:0] RI,
    input  logic [AW-1:0] RX,
    input  logic [AW-1:0] RY,
    output logic [DW-1:0] busX,
    output logic [DW-1:0] busY,
    output logic          RDYX,
    output logic          RDYY,
    output logic [AW:0]   PEND,
    output logic          ISSERR
);

    localparam int unsigned Depth = 2 ** AW;

    logic [DW-1:0]    regs [Depth];
    logic [Depth-1:0] pend;
    logic [Depth-1:0] pendNext;
    logic [AW:0]      pendCnt;
    logic             wrHit;
    logic             issHit;
    logic             issErrNext;

    // Register 0 is never written or reserved, so it stays zero and ready.
    always_comb begin
        wrHit  = WEN && (RW != '0);
        issHit = ISS && (RI != '0);
    end

    // A reservation in the same cycle as a write to that register wins.
    always_comb begin
        pendNext = pend;
        if (wrHit) begin
            pendNext[RW] = 1'b0;
        end
        if (issHit) begin
            pendNext[RI] = 1'b1;
        end
        issErrNext = issHit && pend[RI] && !(wrHit && (RW == RI));
    end

    always_comb begin
        pendCnt = '0;
        for (int unsigned i = 0; i < Depth; i++) begin
            pendCnt = pendCnt + (AW + 1)'(pendNext[i]);
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                regs[i] <= '0;
            end
            pend   <= '0;
            PEND   <= '0;
            ISSERR <= 1'b0;
        end else begin
            if (wrHit) begin
                regs[RW] <= busW;
            end
            pend   <= pendNext;
            PEND   <= pendCnt;
            ISSERR <= issErrNext;
        end
    end

    // Zero-latency read ports.
    always_comb begin
        busX = (RX == '0) ? '0 : regs[RX];
        busY = (RY == '0) ? '0 : regs[RY];
        RDYX = ~pend[RX];
        RDYY = ~pend[RY];
`ifdef REGFILE_BYPASS_EN
        if (wrHit && (RW == RX)) begin
            busX = busW;
            RDYX = 1'b1;
        end
        if (wrHit && (RW == RY)) begin
            busY = busW;
            RDYY = 1'b1;
        end
`endif
    end

endmodule

// File: tb/tb_register_file_sb.sv
// Directed self-checking bench for register_file_sb; follows REGFILE_BYPASS_EN when defined.
module tb_register_file_sb;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 3;

    logic          Clk = 1'b0;
    logic          Rst;
    logic          WEN;
    logic [AW-1:0] RW;
    logic [DW-1:0] busW;
    logic          ISS;
    logic [AW-1:0] RI;
    logic [AW-1:0] RX;
    logic [AW-1:0] RY;
    logic [DW-1:0] busX;
    logic [DW-1:0] busY;
    logic          RDYX;
    logic          RDYY;
    logic [AW:0]   PEND;
    logic          ISSERR;

    int errors = 0;
    int checks = 0;

    register_file_sb #(.DW(DW), .AW(AW)) dut (
        .Clk(Clk), .Rst(Rst), .WEN(WEN), .RW(RW), .busW(busW),
        .ISS(ISS), .RI(RI), .RX(RX), .RY(RY),
        .busX(busX), .busY(busY), .RDYX(RDYX), .RDYY(RDYY),
        .PEND(PEND), .ISSERR(ISSERR)
    );

    always #5 Clk = ~Clk;

    // Advance one edge, then clear strobes 1ns later (away from the edge).
    task automatic tick();
        @(posedge Clk);
        #1;
        WEN = 1'b0;
        ISS = 1'b0;
        Rst = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 1; i < 8; i++) begin
            WEN = 1'b1; RW = AW'(i); busW = DW'($urandom_range(1, 255));
            tick();
        end
        ISS = 1'b1; RI = 3'd5;
        tick();
        Rst = 1'b1; WEN = 1'b1; RW = 3'd1; busW = 8'hFF; ISS = 1'b1; RI = 3'd2;
        tick();
        #1;
        checks++;
        if (PEND !== 4'd0) begin errors++; $display("FAIL reset_pend got=%0d exp=0", PEND); end
        checks++;
        if (ISSERR !== 1'b0) begin errors++; $display("FAIL reset_isserr got=%b exp=0", ISSERR); end
        for (int i = 0; i < 8; i++) begin
            RX = AW'(i); RY = AW'(7 - i);
            #1;
            checks++;
            if (busX !== 8'h00 || RDYX !== 1'b1 || busY !== 8'h00 || RDYY !== 1'b1) begin
                errors++;
                $display("FAIL reset_read r%0d got x=%h/%b y=%h/%b exp 00/1 00/1", i, busX, RDYX, busY, RDYY);
            end
        end
    endtask

    task automatic test_write();
        WEN = 1'b1; RW = 3'd0; busW = 8'hAA;
        tick();
        RX = 3'd0;
        #1;
        checks++;
        if (busX !== 8'h00 || RDYX !== 1'b1) begin
            errors++; $display("FAIL write_r0 got=%h/%b exp=00/1", busX, RDYX);
        end
        WEN = 1'b1; RW = 3'd5; busW = 8'h3C;
        tick();
        RX = 3'd5;
        #1;
        checks++;
        if (busX !== 8'h3C || RDYX !== 1'b1) begin
            errors++; $display("FAIL write_r5 got=%h/%b exp=3c/1", busX, RDYX);
        end
    endtask

    task automatic test_issue();
        ISS = 1'b1; RI = 3'd3;
        tick();
        RX = 3'd3;
        #1;
        checks++;
        if (RDYX !== 1'b0 || PEND !== 4'd1) begin
            errors++; $display("FAIL issue_r3 got rdy=%b pend=%0d exp rdy=0 pend=1", RDYX, PEND);
        end
        WEN = 1'b1; RW = 3'd3; busW = 8'h11;
        tick();
        #1;
        checks++;
        if (busX !== 8'h11 || RDYX !== 1'b1 || PEND !== 4'd0) begin
            errors++; $display("FAIL fill_r3 got=%h/%b pend=%0d exp=11/1 pend=0", busX, RDYX, PEND);
        end
        ISS = 1'b1; RI = 3'd0;
        tick();
        RX = 3'd0;
        #1;
        checks++;
        if (PEND !== 4'd0 || ISSERR !== 1'b0 || RDYX !== 1'b1) begin
            errors++; $display("FAIL issue_r0 got pend=%0d err=%b rdy=%b exp 0/0/1", PEND, ISSERR, RDYX);
        end
    endtask

    task automatic test_double_issue();
        ISS = 1'b1; RI = 3'd4;
        tick();
        checks++;
        if (ISSERR !== 1'b0) begin errors++; $display("FAIL first_issue_err got=%b exp=0", ISSERR); end
        ISS = 1'b1; RI = 3'd4;
        tick();
        checks++;
        if (ISSERR !== 1'b1 || PEND !== 4'd1) begin
            errors++; $display("FAIL double_issue got err=%b pend=%0d exp 1/1", ISSERR, PEND);
        end
        tick();
        checks++;
        if (ISSERR !== 1'b0 || PEND !== 4'd1) begin
            errors++; $display("FAIL err_one_cycle got err=%b pend=%0d exp 0/1", ISSERR, PEND);
        end
        ISS = 1'b1; RI = 3'd4; WEN = 1'b1; RW = 3'd4; busW = 8'h77;
        tick();
        RX = 3'd4;
        #1;
        checks++;
        if (busX !== 8'h77 || RDYX !== 1'b0 || PEND !== 4'd1 || ISSERR !== 1'b0) begin
            errors++;
            $display("FAIL iss_wen_same got=%h/%b pend=%0d err=%b exp=77/0 pend=1 err=0", busX, RDYX, PEND, ISSERR);
        end
    endtask

    task automatic test_mixed();
        ISS = 1'b1; RI = 3'd6;
        tick();
        checks++;
        if (PEND !== 4'd2) begin errors++; $display("FAIL pend_two got=%0d exp=2", PEND); end
        ISS = 1'b1; RI = 3'd2; WEN = 1'b1; RW = 3'd6; busW = 8'h66;
        tick();
        RX = 3'd2; RY = 3'd6;
        #1;
        checks++;
        if (PEND !== 4'd2 || RDYX !== 1'b0 || RDYY !== 1'b1 || busY !== 8'h66 || ISSERR !== 1'b0) begin
            errors++;
            $display("FAIL iss_wen_diff got pend=%0d rdy2=%b rdy6=%b y=%h err=%b exp 2/0/1/66/0",
                     PEND, RDYX, RDYY, busY, ISSERR);
        end
        WEN = 1'b1; RW = 3'd2; busW = 8'h22;
        tick();
        WEN = 1'b1; RW = 3'd4; busW = 8'h44;
        tick();
        #1;
        checks++;
        if (PEND !== 4'd0 || busY !== 8'h66 || RDYX !== 1'b1 || busX !== 8'h22) begin
            errors++; $display("FAIL drain got pend=%0d x=%h/%b y=%h exp 0 22/1 66", PEND, busX, RDYX, busY);
        end
    endtask

    task automatic test_bypass();
        logic [DW-1:0] expX;
        logic          expR;
        WEN = 1'b1; RW = 3'd7; busW = 8'h10;
        tick();
        WEN = 1'b1; RW = 3'd7; busW = 8'h5A; RX = 3'd7; RY = 3'd7;
        #1;
`ifdef REGFILE_BYPASS_EN
        expX = 8'h5A;
`else
        expX = 8'h10;
`endif
        checks++;
        if (busX !== expX || busY !== expX || RDYX !== 1'b1 || RDYY !== 1'b1) begin
            errors++; $display("FAIL bypass_ready got x=%h y=%h rdy=%b%b exp=%h rdy=11", busX, busY, RDYX, RDYY, expX);
        end
        tick();
        ISS = 1'b1; RI = 3'd7;
        tick();
        WEN = 1'b1; RW = 3'd7; busW = 8'hA5;
        #1;
`ifdef REGFILE_BYPASS_EN
        expX = 8'hA5; expR = 1'b1;
`else
        expX = 8'h5A; expR = 1'b0;
`endif
        checks++;
        if (busX !== expX || RDYX !== expR) begin
            errors++; $display("FAIL bypass_pending got=%h/%b exp=%h/%b", busX, RDYX, expX, expR);
        end
        tick();
        #1;
        checks++;
        if (busX !== 8'hA5 || RDYX !== 1'b1 || PEND !== 4'd0) begin
            errors++; $display("FAIL after_bypass got=%h/%b pend=%0d exp=a5/1 pend=0", busX, RDYX, PEND);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] vals [8];
        for (int i = 1; i < 8; i++) begin
            vals[i] = DW'(8'h80 + i * 8'h13);
            WEN = 1'b1; RW = AW'(i); busW = vals[i];
            ISS = 1'b1; RI = AW'(i % 7 + 1);
            tick();
        end
        tick();
        for (int i = 1; i < 8; i++) begin
            RX = AW'(i); RY = AW'(i);
            #1;
            checks++;
            if (busX !== vals[i] || busY !== vals[i]) begin
                errors++; $display("FAIL b2b_data r%0d got=%h/%h exp=%h", i, busX, busY, vals[i]);
            end
        end
        // Last issue reserved r1 after its write; every other reservation was later filled.
        checks++;
        if (PEND !== 4'd1) begin errors++; $display("FAIL b2b_pend got=%0d exp=1", PEND); end
        RX = 3'd1; RY = 3'd2;
        #1;
        checks++;
        if (RDYX !== 1'b0 || RDYY !== 1'b1) begin
            errors++; $display("FAIL b2b_ready got=%b%b exp=01", RDYX, RDYY);
        end
    endtask

    initial begin
        Rst = 1'b1; WEN = 1'b0; RW = '0; busW = '0; ISS = 1'b0; RI = '0; RX = '0; RY = '0;
        tick();
        test_reset();
        test_write();
        test_issue();
        test_double_issue();
        test_mixed();
        test_bypass();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
